mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Two-master to one-slave arbiter on the picorv32 native memory bus (valid/ready/addr/wdata/wstrb/rdata). It shares one slave port (RAM, or the i2cm register window) between the CPU core (m0) and a second master such as a DMA or test master (m1). Arbitration is round-robin, and the grant is held for one whole transfer. A watchdog completes stalled transfers with an error word, so a hung slave cannot lock up the CPU.

Parameters:
AW, 32, address width
DW, 32, data width (wstrb width = DW/8)
TIMEOUT, 1024, maximum cycles a granted transfer may wait for s_ready; 0 disables the watchdog
ERR_RDATA, 32'hDEADBEEF, rdata returned on a timed-out transfer

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
m0_valid  in  1  master 0 request; held until m0_ready
m0_ready  out  1  master 0 transfer complete
m0_addr  in  AW  master 0 address
m0_wdata  in  DW  master 0 write data
m0_wstrb  in  DW/8  master 0 byte strobes; 0 means read
m0_rdata  out  DW  master 0 read data, valid when m0_ready
m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata  same roles as m0_*, for master 1
s_valid  out  1  slave request
s_ready  in  1  slave completion
s_addr  out  AW  slave address
s_wdata  out  DW  slave write data
s_wstrb  out  DW/8  slave byte strobes
s_rdata  in  DW  slave read data
busy  out  1  a grant is active
timeout_err  out  1  one-cycle pulse when a transfer is aborted by the watchdog

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset state:
  - state=IDLE, last=1 (so m0 wins the first tie), counter=0.
  - busy=0, timeout_err=0, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0.
  - s_valid=0, s_addr=0, s_wdata=0, s_wstrb=0.
- Registered state: state in {IDLE, GNT0, GNT1}, last-served pointer last, watchdog counter cnt (width clog2(TIMEOUT+1)).
- IDLE:
  - Only m0_valid set -> GNT0. Only m1_valid set -> GNT1.
  - Both set -> grant the master that is not last.
  - Neither set -> stay in IDLE.
  - Outputs while IDLE: s_valid=0, s_* buses=0, both mx_ready=0.
  - Grant latency is one cycle: a request sampled in IDLE at edge N gives s_valid=1 after edge N.
- GNTx, pass-through paths (combinational):
  - s_valid=mx_valid; s_addr, s_wdata, s_wstrb = the mx_* inputs.
  - mx_ready=s_ready; mx_rdata=s_rdata.
  - Non-granted master: ready=0, rdata=0.
- GNTx, completion: s_ready && mx_valid -> next state IDLE, last<=x, cnt<=0. At least one IDLE cycle separates any two grants.
- GNTx, abandon: mx_valid==0 while granted -> IDLE; last is unchanged and no ready is returned.
- GNTx, watchdog (TIMEOUT>0):
  - cnt increments each GNT cycle without s_ready.
  - When cnt==TIMEOUT-1 and s_ready==0, that cycle: mx_ready=1, mx_rdata=ERR_RDATA, s_valid=0, timeout_err=1.
  - Next state IDLE, last<=x.
  - Any late s_ready from the slave while IDLE is ignored.
- s_ready on the exact cycle cnt==TIMEOUT-1 is a normal completion, with no error.
- busy = (state!=IDLE).
- Reset mid-transfer: all state clears immediately, outputs return to reset values, and no ready is emitted.
- Writes and reads are treated identically; wstrb is only forwarded.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_GNT0=2'd1, ST_GNT1=2'd2) and the default ERR_RDATA value.
- One natural sub-module, bus_timer: cnt register with clear/enable inputs and an expire output, parameterised by TIMEOUT.
- The arbiter FSM and the output muxes stay in mem_arbiter.

Test Plan:
- m0 read of 0x00000100, slave returns 0x12345678 with s_ready 2 cycles after s_valid -> s_valid high 1 cycle after m0_valid; m0_ready for exactly 1 cycle with m0_rdata=0x12345678; m1_ready stays 0.
- m0 and m1 both assert valid from reset -> m0 served first, then m1 after one IDLE cycle. Both re-request -> m1 is not served twice in a row, and the order alternates m0, m1, m0, m1 over 4 transfers.
- m1 write to 0x50000004 of 0xA5 with wstrb=4'b0001 -> s_addr, s_wdata, s_wstrb equal the m1 values while s_valid=1; m1_ready follows s_ready in the same cycle.
- With TIMEOUT=16, slave never asserts s_ready on an m0 request -> on the 16th grant cycle m0_ready=1, m0_rdata=0xDEADBEEF, timeout_err=1 for one cycle, s_valid=0; a later m1 request is granted normally.
- s_ready asserted exactly on grant cycle 16 (TIMEOUT=16) -> normal completion with slave data and timeout_err=0.
- rst_n pulsed low while in GNT1 with the slave stalled -> all outputs 0 asynchronously; after release, a pending m0 request is granted first (last=1).

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
//   - FSM state encoding (IDLE, grant to m0, grant to m1)
//   - default rdata returned when the watchdog aborts a transfer
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter_timer.sv
// Watchdog counter for a granted bus transfer.
//   clk, rst_n : clock / async active-low reset
//   clr        : return the count to zero (takes priority over en)
//   en         : count this cycle (granted and slave not ready)
//   expire     : this is the last allowed wait cycle and the slave is still
//                not ready; the arbiter aborts the transfer
// TIMEOUT == 0 disables expiry entirely.
module bus_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // The count never passes LIMIT: expiry always ends the grant, which clears it.
  assign expire = (TIMEOUT > 0) && en && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one picorv32-native-bus slave between two
// masters (m0 = CPU, m1 = DMA/test master). A grant lasts one whole
// transfer; a watchdog completes stalled transfers with ERR_RDATA.
//   mX_valid/ready/addr/wdata/wstrb/rdata : master ports (wstrb==0 is a read)
//   s_valid/ready/addr/wdata/wstrb/rdata  : shared slave port
//   busy        : a grant is active
//   timeout_err : one-cycle pulse when the watchdog aborts a transfer
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            TIMEOUT   = 1024,
  parameter logic [DW-1:0] ERR_RDATA = DW'(ERR_RDATA_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_valid,
  output logic            m0_ready,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_valid,
  output logic            m1_ready,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  output logic [DW-1:0]   m1_rdata,
  output logic            s_valid,
  input  logic            s_ready,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  input  logic [DW-1:0]   s_rdata,
  output logic            busy,
  output logic            timeout_err
);

  // Masters gathered into packed arrays so the grant mux is a single index.
  logic [1:0]                 m_valid, m_ready;
  logic [1:0][AW-1:0]         m_addr;
  logic [1:0][DW-1:0]         m_wdata, m_rdata;
  logic [1:0][DW/8-1:0]       m_wstrb;

  assign m_valid = {m1_valid, m0_valid};
  assign m_addr  = {m1_addr,  m0_addr};
  assign m_wdata = {m1_wdata, m0_wdata};
  assign m_wstrb = {m1_wstrb, m0_wstrb};
  assign m0_ready = m_ready[0];
  assign m1_ready = m_ready[1];
  assign m0_rdata = m_rdata[0];
  assign m1_rdata = m_rdata[1];

  arb_state_e state_q, state_d;
  logic       last_q, last_d;   // index of the master served last
  logic       sel;
  logic       expire;

  assign busy = (state_q != ST_IDLE);
  assign sel  = (state_q == ST_GNT1);

  bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_d == ST_IDLE),
    .en     (busy && !s_ready),
    .expire (expire)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m_ready     = '0;
    m_rdata     = '0;
    timeout_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A late s_ready from an aborted transfer lands here and is ignored.
        if (m_valid[0] && m_valid[1]) state_d = last_q ? ST_GNT0 : ST_GNT1;
        else if (m_valid[0])          state_d = ST_GNT0;
        else if (m_valid[1])          state_d = ST_GNT1;
      end
      ST_GNT0, ST_GNT1: begin
        s_addr       = m_addr[sel];
        s_wdata      = m_wdata[sel];
        s_wstrb      = m_wstrb[sel];
        m_rdata[sel] = s_rdata;
        if (!m_valid[sel]) begin
          // Master withdrew: drop the grant without a ready, fairness untouched.
          state_d = ST_IDLE;
        end else if (s_ready) begin
          // Slave wins over the watchdog on the final wait cycle.
          s_valid      = 1'b1;
          m_ready[sel] = 1'b1;
          state_d      = ST_IDLE;
          last_d       = sel;
        end else if (expire) begin
          m_ready[sel] = 1'b1;
          m_rdata[sel] = ERR_RDATA;
          timeout_err  = 1'b1;
          state_d      = ST_IDLE;
          last_d       = sel;
        end else begin
          s_valid = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule
